// File: rtl/prescaler.sv
// Prescaler: emits a one-cycle registered tick every N enabled clock cycles,
// where N is derived at elaboration from a target interval and the clock period.
module prescaler #(
    parameter logic [15:0] CNT_TIME_NS   = 16'd1000,
    parameter logic [15:0] CLK_PERIOD_NS = 16'd40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        out,
    output logic [15:0] cnt_dbg
);

    // A requested interval shorter than one clock period degenerates to N=1.
    localparam logic [15:0] QUOT     = CNT_TIME_NS / CLK_PERIOD_NS;
    localparam logic [15:0] N        = (QUOT == 16'd0) ? 16'd1 : QUOT;
    localparam logic [15:0] TERM_CNT = N - 16'd1;

    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'd0;
            out <= 1'b0;
        end else if (!en) begin
            cnt <= 16'd0;
            out <= 1'b0;
        end else if (cnt == TERM_CNT) begin
            cnt <= 16'd0;
            out <= 1'b1;
        end else begin
            cnt <= cnt + 16'd1;
            out <= 1'b0;
        end
    end

    assign cnt_dbg = cnt;

endmodule

// File: tb/tb_prescaler.sv
// Bench for prescaler: four configurations (N=5, N=1, N=1 from a zero quotient,
// N=65535) driven side by side and compared against an enabled-edge-count model.
module tb_prescaler;

    logic        clk;
    logic        rst_n;
    logic        en_v  [4];
    logic        out_v [4];
    logic [15:0] cnt_v [4];

    int n_assert = 0;
    int n_fail   = 0;

    // Model: consecutive enabled edges since the last reset or disabled edge.
    int k  [4];
    int nn [4] = '{5, 1, 1, 65535};

    initial clk = 1'b0;
    always #20 clk = ~clk;

    prescaler #(.CNT_TIME_NS(16'd200), .CLK_PERIOD_NS(16'd40)) u_n5 (
        .clk(clk), .rst_n(rst_n), .en(en_v[0]), .out(out_v[0]), .cnt_dbg(cnt_v[0]));
    prescaler #(.CNT_TIME_NS(16'd40), .CLK_PERIOD_NS(16'd40)) u_n1 (
        .clk(clk), .rst_n(rst_n), .en(en_v[1]), .out(out_v[1]), .cnt_dbg(cnt_v[1]));
    prescaler #(.CNT_TIME_NS(16'd30), .CLK_PERIOD_NS(16'd40)) u_q0 (
        .clk(clk), .rst_n(rst_n), .en(en_v[2]), .out(out_v[2]), .cnt_dbg(cnt_v[2]));
    prescaler #(.CNT_TIME_NS(16'd65535), .CLK_PERIOD_NS(16'd1)) u_big (
        .clk(clk), .rst_n(rst_n), .en(en_v[3]), .out(out_v[3]), .cnt_dbg(cnt_v[3]));

    task automatic chk(input string tag, input int idx, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk("cnt_dbg", i, cnt_v[i], 16'(k[i] % nn[i]));
            chk("out", i, {15'd0, out_v[i]},
                {15'd0, (k[i] > 0) && (k[i] % nn[i] == 0)});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (en_v[i]) k[i]++;
            else         k[i] = 0;
        end
        #1;
        check_all();
    endtask

    task automatic async_reset_pulse();
        #10;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) k[i] = 0;
        check_all();
        #5;
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en_v[i] = 1'b0;
            k[i]    = 0;
        end
        #5;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // N=1 instances: high from the first enabled edge onward
        en_v[1] = 1'b1;
        en_v[2] = 1'b1;
        for (int c = 0; c < 6; c++) tick();

        // N=5 free run
        en_v[0] = 1'b1;
        for (int c = 0; c < 12; c++) tick();

        // Drop enable at count 3, re-raise two cycles later
        guard = 0;
        while ((k[0] % 5) != 3 && guard < 10) begin
            tick();
            guard++;
        end
        chk("reach_cnt3", 0, cnt_v[0], 16'd3);
        en_v[0] = 1'b0;
        tick();
        tick();
        en_v[0] = 1'b1;
        for (int c = 0; c < 7; c++) tick();

        // Asynchronous reset between edges at count 4
        guard = 0;
        while ((k[0] % 5) != 4 && guard < 10) begin
            tick();
            guard++;
        end
        chk("reach_cnt4", 0, cnt_v[0], 16'd4);
        async_reset_pulse();
        for (int c = 0; c < 7; c++) tick();

        // Randomised enables with occasional mid-cycle resets
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) en_v[i] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) async_reset_pulse();
            tick();
        end

        // N=65535: full count, wrap with a single pulse, never 65535
        for (int i = 0; i < 3; i++) en_v[i] = 1'b0;
        en_v[3] = 1'b1;
        for (int c = 0; c < 65540; c++) tick();
        en_v[3] = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
